// File: rtl/data_register_file.sv
// Parametrised operand store: two registered read ports with write bypass and a
// hardware clear sequencer that initialises every entry after reset or on request.
module data_register_file #(
  parameter int unsigned            DATA_WIDTH  = 8,
  parameter int unsigned            ADDR_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable_write,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic                  read_valid_a,
  input  logic                  read_enable_b,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  output logic [DATA_WIDTH-1:0] read_data_b,
  output logic                  read_valid_b,
  input  logic                  clear_request,
  output logic                  ready,
  output logic                  write_error
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {StClear, StReady} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  ready_q;
  logic                  write_error_q;
  logic                  valid_a_q, valid_b_q;
  logic [DATA_WIDTH-1:0] data_a_q, data_b_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  write_accept;
  logic                  clear_write;
  logic                  fire_a, fire_b;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;

  always_comb begin
    write_accept = enable_write & (state_q == StReady) & ~clear_request;
    clear_write  = (state_q == StClear);
    fire_a       = read_enable_a & ready_q & ~clear_request;
    fire_b       = read_enable_b & ready_q & ~clear_request;
    // A write landing on the same edge wins over the stale array content.
    sel_a = (write_accept && (write_addr == read_addr_a)) ? write_data : mem_q[read_addr_a];
    sel_b = (write_accept && (write_addr == read_addr_b)) ? write_data : mem_q[read_addr_b];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StClear;
      ptr_q         <= '0;
      ready_q       <= 1'b0;
      write_error_q <= 1'b0;
      valid_a_q     <= 1'b0;
      valid_b_q     <= 1'b0;
      data_a_q      <= '0;
      data_b_q      <= '0;
    end else begin
      write_error_q <= enable_write & ~write_accept;
      valid_a_q     <= fire_a;
      valid_b_q     <= fire_b;
      if (fire_a) data_a_q <= sel_a;
      if (fire_b) data_b_q <= sel_b;
      unique case (state_q)
        StClear: begin
          if (ptr_q == LastAddr) begin
            state_q <= StReady;
            ready_q <= 1'b1;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + ADDR_WIDTH'(1);
          end
        end
        StReady: begin
          if (clear_request) begin
            state_q <= StClear;
            ready_q <= 1'b0;
            ptr_q   <= '0;
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

  // Array has no reset; the sequencer overwrites every entry instead.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (clear_write) begin
        mem_q[ptr_q] <= CLEAR_VALUE;
      end else if (write_accept) begin
        mem_q[write_addr] <= write_data;
      end
    end
  end

  assign read_data_a  = data_a_q;
  assign read_valid_a = valid_a_q;
  assign read_data_b  = data_b_q;
  assign read_valid_b = valid_b_q;
  assign ready        = ready_q;
  assign write_error  = write_error_q;

endmodule

// File: tb/tb_data_register_file.sv
// Directed bench for data_register_file with DEPTH=16 and clear value 8'hA5.
module tb_data_register_file;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam logic [DW-1:0] CV = 8'hA5;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable_write;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          read_enable_a;
  logic [AW-1:0] read_addr_a;
  logic [DW-1:0] read_data_a;
  logic          read_valid_a;
  logic          read_enable_b;
  logic [AW-1:0] read_addr_b;
  logic [DW-1:0] read_data_b;
  logic          read_valid_b;
  logic          clear_request;
  logic          ready;
  logic          write_error;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  data_register_file #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CLEAR_VALUE(CV)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable_write (enable_write),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .read_enable_a(read_enable_a),
    .read_addr_a  (read_addr_a),
    .read_data_a  (read_data_a),
    .read_valid_a (read_valid_a),
    .read_enable_b(read_enable_b),
    .read_addr_b  (read_addr_b),
    .read_data_b  (read_data_b),
    .read_valid_b (read_valid_b),
    .clear_request(clear_request),
    .ready        (ready),
    .write_error  (write_error)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    enable_write  = 1'b0;
    write_addr    = '0;
    write_data    = '0;
    read_enable_a = 1'b0;
    read_addr_a   = '0;
    read_enable_b = 1'b0;
    read_addr_b   = '0;
    clear_request = 1'b0;
  endtask

  task automatic read_a(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
    read_enable_a = 1'b1;
    read_addr_a   = addr;
    tick();
    read_enable_a = 1'b0;
    checks++;
    if (read_valid_a !== 1'b1 || read_data_a !== exp)
      $display("FAIL %s: valid=%b data=%h, expected valid=1 data=%h", name, read_valid_a,
               read_data_a, exp);
    else passed++;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({ready, write_error, read_valid_a, read_valid_b} !== 4'b0000 ||
        read_data_a !== 8'h00 || read_data_b !== 8'h00)
      $display("FAIL reset_values: rdy=%b werr=%b va=%b vb=%b da=%h db=%h, expected all 0",
               ready, write_error, read_valid_a, read_valid_b, read_data_a, read_data_b);
    else passed++;
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (ready !== (i == 16))
        $display("FAIL init_ready edge %0d: ready=%b expected %b", i, ready, (i == 16));
      else passed++;
    end
    for (int a = 0; a < 16; a++) begin
      read_enable_a = 1'b1;
      read_addr_a   = AW'(a);
      read_enable_b = 1'b1;
      read_addr_b   = AW'(15 - a);
      tick();
      checks++;
      if (read_valid_a !== 1'b1 || read_valid_b !== 1'b1 || read_data_a !== CV ||
          read_data_b !== CV)
        $display("FAIL init_read addr %0d: va=%b vb=%b da=%h db=%h expected 1 1 a5 a5", a,
                 read_valid_a, read_valid_b, read_data_a, read_data_b);
      else passed++;
    end
    idle();
    tick();
    checks++;
    if (read_valid_a !== 1'b0 || read_valid_b !== 1'b0)
      $display("FAIL init_valid_drop: va=%b vb=%b expected 0 0", read_valid_a, read_valid_b);
    else passed++;
  endtask

  task automatic test_write_read();
    enable_write = 1'b1;
    write_addr   = 4'd7;
    write_data   = 8'h3C;
    tick();
    idle();
    read_enable_a = 1'b1;
    read_addr_a   = 4'd7;
    read_enable_b = 1'b1;
    read_addr_b   = 4'd6;
    tick();
    checks++;
    if (read_valid_a !== 1'b1 || read_valid_b !== 1'b1 || read_data_a !== 8'h3C ||
        read_data_b !== CV)
      $display("FAIL write_read: va=%b vb=%b da=%h db=%h expected 1 1 3c a5", read_valid_a,
               read_valid_b, read_data_a, read_data_b);
    else passed++;
    idle();
    read_addr_a = 4'd0;
    tick();
    checks++;
    if (read_valid_a !== 1'b0 || read_data_a !== 8'h3C || read_data_b !== CV)
      $display("FAIL data_hold: va=%b da=%h db=%h expected 0 3c a5", read_valid_a, read_data_a,
               read_data_b);
    else passed++;
  endtask

  task automatic test_bypass();
    enable_write  = 1'b1;
    write_addr    = 4'd9;
    write_data    = 8'h5A;
    read_enable_a = 1'b1;
    read_addr_a   = 4'd9;
    read_enable_b = 1'b1;
    read_addr_b   = 4'd9;
    tick();
    checks++;
    if (read_valid_a !== 1'b1 || read_valid_b !== 1'b1 || read_data_a !== 8'h5A ||
        read_data_b !== 8'h5A)
      $display("FAIL bypass_both: va=%b vb=%b da=%h db=%h expected 1 1 5a 5a", read_valid_a,
               read_valid_b, read_data_a, read_data_b);
    else passed++;
    idle();
    read_a(4'd9, 8'h5A, "bypass_followup");
    // Bypass on port A only; port B reads an untouched entry.
    enable_write  = 1'b1;
    write_addr    = 4'd3;
    write_data    = 8'h66;
    read_enable_a = 1'b1;
    read_addr_a   = 4'd3;
    read_enable_b = 1'b1;
    read_addr_b   = 4'd8;
    tick();
    checks++;
    if (read_data_a !== 8'h66 || read_data_b !== CV)
      $display("FAIL bypass_split: da=%h db=%h expected 66 a5", read_data_a, read_data_b);
    else passed++;
    idle();
  endtask

  task automatic test_write_during_clear();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    enable_write = 1'b1;
    write_addr   = 4'd2;
    write_data   = 8'hFF;
    tick();
    idle();
    checks++;
    if (write_error !== 1'b1)
      $display("FAIL clear_werr_pulse: write_error=%b expected 1", write_error);
    else passed++;
    tick();
    checks++;
    if (write_error !== 1'b0)
      $display("FAIL clear_werr_drop: write_error=%b expected 0", write_error);
    else passed++;
    repeat (10) tick();
    checks++;
    if (ready !== 1'b1) $display("FAIL clear_ready: ready=%b expected 1", ready);
    else passed++;
    read_a(4'd2, CV, "dropped_write_addr2");
  endtask

  task automatic test_clear_collision();
    enable_write = 1'b1;
    write_addr   = 4'd4;
    write_data   = 8'h77;
    tick();
    idle();
    read_a(4'd4, 8'h77, "pre_clear_addr4");
    clear_request = 1'b1;
    enable_write  = 1'b1;
    write_addr    = 4'd4;
    write_data    = 8'h11;
    read_enable_a = 1'b1;
    read_addr_a   = 4'd4;
    tick();
    idle();
    checks++;
    if (write_error !== 1'b1 || read_valid_a !== 1'b0 || ready !== 1'b0)
      $display("FAIL collision: werr=%b va=%b rdy=%b expected 1 0 0", write_error,
               read_valid_a, ready);
    else passed++;
    for (int i = 2; i <= 17; i++) begin
      if (i == 5) clear_request = 1'b1;  // ignored while clearing
      tick();
      clear_request = 1'b0;
      checks++;
      if (ready !== (i == 17) || write_error !== 1'b0)
        $display("FAIL reclear edge %0d: ready=%b werr=%b expected %b 0", i, ready,
                 write_error, (i == 17));
      else passed++;
    end
    read_a(4'd4, CV, "reclear_addr4");
  endtask

  task automatic test_mid_clear_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    reset         = 1'b1;
    enable_write  = 1'b1;
    write_addr    = 4'd1;
    write_data    = 8'h42;
    read_enable_a = 1'b1;
    read_enable_b = 1'b1;
    tick();
    reset        = 1'b0;
    enable_write = 1'b0;
    checks++;
    if (write_error !== 1'b0 || ready !== 1'b0)
      $display("FAIL midreset_cycle: werr=%b ready=%b expected 0 0", write_error, ready);
    else passed++;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (ready !== (i == 16) || write_error !== 1'b0 || read_valid_a !== 1'b0 ||
          read_valid_b !== 1'b0)
        $display("FAIL midreset edge %0d: ready=%b werr=%b va=%b vb=%b expected %b 0 0 0", i,
                 ready, write_error, read_valid_a, read_valid_b, (i == 16));
      else passed++;
    end
    idle();
    read_a(4'd1, CV, "midreset_addr1");
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_write_during_clear();
    test_clear_collision();
    test_mid_clear_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
